relogio_param: RTL
==================

# relogio_param

Parametrised successor to the team's Johnson-output clock: an HH:MM:SS time-of-day counter with an internal seconds prescaler, run/pause, validated load of hours, minutes and seconds, and a 12/24-hour display mode. Each digit is driven as a 10-bit one-hot code, bit n set for digit n. An optional alarm comparator is included. The block sits between the board clock and the display driver.

## Interface
Parameters:
- TICK_DIV, default 50_000_000: clk cycles per second. Legal range is 1 or more; 1 means a tick every cycle.
- DIV_W, default 26: prescaler width. Must satisfy 2^DIV_W ≥ TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- run  in  1  1 = time advances; 0 = prescaler and time hold.
- mode_12h  in  1  display mode: 1 = 12-hour, 0 = 24-hour. Display only; internal time is always 24h.
- LD_time  in  1  load strobe, sampled on each rising edge.
- H_in1  in  2; H_in0  in  4  load hours, BCD, 24h.
- M_in1  in  4; M_in0  in  4  load minutes, BCD.
- S_in1  in  4; S_in0  in  4  load seconds, BCD.
- H_out1, H_out0, M_out1, M_out0, S_out1, S_out0  out  10 each  one-hot digit codes.
- pm  out  1  1 when internal hour ≥ 12, in both modes.
- sec_tick  out  1  one-cycle pulse on each seconds advance.
- day_tick  out  1  one-cycle pulse on the 23:59:59→00:00:00 wrap.
- ld_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- State: prescaler div (DIV_W bits), internal hour h (0–23), minute m (0–59), second s (0–59), all in BCD.
- Prescaler: while run=1, div counts 0..TICK_DIV-1 and wraps. A tick occurs in the cycle where div=TICK_DIV-1 and run=1.
- On a tick: s increments. At s=59, s goes to 0 and m increments. At m=59, m goes to 0 and h increments. At h=23, h goes to 0 and day_tick is asserted.
- Load: LD_time=1 at an edge with valid inputs writes h, m, s and clears div to 0.
  - Load has priority over a coincident tick. The tick is dropped, and neither sec_tick nor day_tick fires.
- Invalid load: any BCD digit > 9, hours > 23, minutes > 59, or seconds > 59.
  - State is unchanged, div keeps counting, and ld_err pulses on the next cycle.
- LD_time held high for several cycles reloads on every edge; div stays at 0.
- Display:
  - 24h mode: the hour digits decode h directly.
  - 12h mode: h=0 displays 12; h=1..12 displays h; h=13..23 displays h−12.
  - Minute and second digits are identical in both modes.
  - Outputs are a combinational decode of the state registers plus mode_12h. A mode change therefore appears in the same cycle.
- run=0: div, h, m and s hold. Loads are still accepted while paused.

## Timing
- Reset values:
  - Time is 00:00:00 and div=0.
  - M_out*, S_out* and H_out1/H_out0 in 24h mode are 10'b0000000001.
  - In 12h mode, H_out1=10'b0000000010 and H_out0=10'b0000000100.
  - pm, sec_tick, day_tick and ld_err are 0.
- Reset asserted mid-count clears everything immediately, without waiting for a clock edge. The first tick after release occurs TICK_DIV cycles after the first enabled edge.
- Time outputs change in the cycle after the tick edge. sec_tick and day_tick are registered and high during that same cycle.
- Load latency is 1 edge. After a load, the first tick follows TICK_DIV cycles later.
- TICK_DIV=1: a tick occurs on every edge with run=1.

## Configuration
- RELOGIO_ALARM_EN defined:
  - Adds inputs AL_set (1), AL_ack (1) and output alarm (1), plus an alarm register holding hh:mm.
  - AL_set loads the alarm from H_in*/M_in* using the same validity rules; an invalid value pulses ld_err.
  - AL_set arms the alarm. If AL_set and LD_time coincide, both loads apply.
  - alarm goes to 1 on the tick that produces hh:mm:00 equal to the alarm value while the alarm is armed.
  - alarm stays high until AL_ack or minute end (mm:59→next), whichever comes first.
  - AL_ack also disarms the alarm until the next AL_set.
  - Reset clears the alarm register to 00:00 with the alarm disarmed and alarm=0.
- Not defined: these ports and registers are absent; all other behaviour is identical.

## Test plan
- Reset, TICK_DIV=4, run=1: outputs decode 00:00:00; after 4 cycles sec_tick pulses and S_out0=10'b0000000010.
- Load 23:59:58, TICK_DIV=4: the second tick gives 00:00:00, with day_tick high in the same cycle as sec_tick; pm goes 1→0.
- Load H=24, M=00, S=00: ld_err pulses one cycle later and time is unchanged. Repeat with M_in0=4'hA and S_in1=6; each is rejected.
- mode_12h=1, load 13:05:00: hour digits show 01 and pm=1. Load 00:00:00: hour digits show 12 and pm=0. Toggling mode switches the display in the same cycle.
- run=0 for 10 cycles mid-count: time and div hold. LD_time asserted on the tick cycle: the load wins and no sec_tick fires.
- With RELOGIO_ALARM_EN: AL_set 07:30, load 07:29:59; the next tick raises alarm. AL_ack clears it, and no re-raise occurs without a new AL_set.

Source files
------------

// File: rtl/relogio_param.sv
// relogio_param: BCD HH:MM:SS clock with prescaler, validated load, 12/24h one-hot display.
// Define RELOGIO_ALARM_EN to add the hh:mm alarm comparator (AL_set, AL_ack, alarm).
module relogio_param #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       LD_time,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic [3:0] S_in1,
  input  logic [3:0] S_in0,
`ifdef RELOGIO_ALARM_EN
  input  logic       AL_set,
  input  logic       AL_ack,
  output logic       alarm,
`endif
  output logic [9:0] H_out1,
  output logic [9:0] H_out0,
  output logic [9:0] M_out1,
  output logic [9:0] M_out0,
  output logic [9:0] S_out1,
  output logic [9:0] S_out0,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_tick,
  output logic       ld_err
);
  logic [DIV_W-1:0] r_div;
  logic [1:0] r_h1;
  logic [3:0] r_h0, r_m1, r_m0, r_s1, r_s0;
  logic r_sec_tick, r_day_tick, r_ld_err;
  logic w_tick, w_hm_ok, w_ld_ok, w_ld, w_s_wrap, w_m_wrap, w_h_wrap, w_hinc;
  logic [1:0] w_nh1;
  logic [3:0] w_nh0, w_nm1, w_nm0, w_ns1, w_ns0, w_hd1, w_hd0;
  logic [4:0] w_hb, w_hd;
  assign w_tick   = run && (r_div == DIV_W'(TICK_DIV - 1));
  assign w_hm_ok  = (H_in0 <= 4'd9) && ((H_in1 < 2'd2) || (H_in1 == 2'd2 && H_in0 <= 4'd3))
                 && (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
  assign w_ld_ok  = w_hm_ok && (S_in1 <= 4'd5) && (S_in0 <= 4'd9);
  assign w_ld     = LD_time && w_ld_ok;
  assign w_s_wrap = (r_s1 == 4'd5) && (r_s0 == 4'd9);
  assign w_m_wrap = (r_m1 == 4'd5) && (r_m0 == 4'd9);
  assign w_h_wrap = (r_h1 == 2'd2) && (r_h0 == 4'd3);
  assign w_hinc   = w_s_wrap && w_m_wrap;
  always_comb begin
    w_ns0 = (r_s0 == 4'd9) ? 4'd0 : r_s0 + 4'd1;
    w_ns1 = (r_s0 != 4'd9) ? r_s1 : (r_s1 == 4'd5) ? 4'd0 : r_s1 + 4'd1;
    w_nm0 = !w_s_wrap ? r_m0 : (r_m0 == 4'd9) ? 4'd0 : r_m0 + 4'd1;
    w_nm1 = !(w_s_wrap && r_m0 == 4'd9) ? r_m1 : (r_m1 == 4'd5) ? 4'd0 : r_m1 + 4'd1;
    w_nh0 = !w_hinc ? r_h0 : (w_h_wrap || r_h0 == 4'd9) ? 4'd0 : r_h0 + 4'd1;
    w_nh1 = !w_hinc ? r_h1 : w_h_wrap ? 2'd0 : (r_h0 == 4'd9) ? r_h1 + 2'd1 : r_h1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
      r_h1 <= '0;
      r_h0 <= '0;
      r_m1 <= '0;
      r_m0 <= '0;
      r_s1 <= '0;
      r_s0 <= '0;
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_tick && !w_ld;
      r_day_tick <= w_tick && !w_ld && w_hinc && w_h_wrap;
      if (w_ld) begin
        r_div <= '0;
        r_h1 <= H_in1;
        r_h0 <= H_in0;
        r_m1 <= M_in1;
        r_m0 <= M_in0;
        r_s1 <= S_in1;
        r_s0 <= S_in0;
      end else if (run) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          r_h1 <= w_nh1;
          r_h0 <= w_nh0;
          r_m1 <= w_nm1;
          r_m0 <= w_nm0;
          r_s1 <= w_ns1;
          r_s0 <= w_ns0;
        end
      end
    end
  end
`ifdef RELOGIO_ALARM_EN
  logic [1:0] r_al_h1;
  logic [3:0] r_al_h0, r_al_m1, r_al_m0;
  logic r_al_armed, r_alarm, w_al_hit;
  assign w_al_hit = w_tick && !w_ld && r_al_armed && w_ns1 == 4'd0 && w_ns0 == 4'd0
                 && {w_nh1, w_nh0, w_nm1, w_nm0} == {r_al_h1, r_al_h0, r_al_m1, r_al_m0};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_al_h1 <= '0;
      r_al_h0 <= '0;
      r_al_m1 <= '0;
      r_al_m0 <= '0;
      r_al_armed <= 1'b0;
      r_alarm <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= (LD_time && !w_ld_ok) || (AL_set && !w_hm_ok);
      if (AL_ack) r_al_armed <= 1'b0;
      if (AL_set && w_hm_ok) begin
        r_al_h1 <= H_in1;
        r_al_h0 <= H_in0;
        r_al_m1 <= M_in1;
        r_al_m0 <= M_in0;
        r_al_armed <= 1'b1;
      end
      // the raising tick is itself a minute end, so raise outranks the minute-end clear
      r_alarm <= AL_ack ? 1'b0 : w_al_hit ? 1'b1 : (w_tick && !w_ld && w_s_wrap) ? 1'b0 : r_alarm;
    end
  end
  assign alarm = r_alarm;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ld_err <= 1'b0;
    else r_ld_err <= LD_time && !w_ld_ok;
  end
`endif
  assign w_hb = 5'(r_h1) * 5'd10 + 5'(r_h0);
  assign w_hd = !mode_12h ? w_hb : (w_hb == 5'd0) ? 5'd12 : (w_hb > 5'd12) ? w_hb - 5'd12 : w_hb;
  assign w_hd1 = (w_hd >= 5'd20) ? 4'd2 : (w_hd >= 5'd10) ? 4'd1 : 4'd0;
  assign w_hd0 = (w_hd >= 5'd20) ? 4'(w_hd - 5'd20) : (w_hd >= 5'd10) ? 4'(w_hd - 5'd10) : 4'(w_hd);
  assign H_out1   = 10'd1 << w_hd1;
  assign H_out0   = 10'd1 << w_hd0;
  assign M_out1   = 10'd1 << r_m1;
  assign M_out0   = 10'd1 << r_m0;
  assign S_out1   = 10'd1 << r_s1;
  assign S_out0   = 10'd1 << r_s0;
  assign pm       = w_hb >= 5'd12;
  assign sec_tick = r_sec_tick;
  assign day_tick = r_day_tick;
  assign ld_err   = r_ld_err;
endmodule
